// File: rtl/fb_bank_scheduler.sv
// Frame-buffer port-A write sequencer: camera capture, back-bank clear and
// ping-pong bank swap aligned to display vsync so the reader never tears.
module fb_bank_scheduler #(
  parameter int unsigned FRAME_WORDS = 76800,
  parameter int unsigned ADDR_W      = 18,
  parameter logic [31:0] FILL_VALUE  = 32'h0000_0000
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              cam_frame_start,
  input  logic              cam_frame_end,
  input  logic              cam_valid,
  input  logic [31:0]       cam_data,
  input  logic              disp_vsync,
  input  logic              clear_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_data,
  output logic [ADDR_W-1:0] disp_base,
  output logic              frame_done,
  output logic              clear_busy,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam int unsigned       CNT_W      = ADDR_W - 1;
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(FRAME_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT_SWAP,
    S_CLEAR
  } state_e;

  state_e            state_q;
  logic              wb_q;
  logic              db_q;
  logic              pend_q;
  logic [CNT_W-1:0]  wcnt_q;
  logic [CNT_W-1:0]  ccnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] base_q;
  logic              done_q;
  logic              busy_q;
  logic              ovf_q;
  logic [15:0]       drop_q;
  logic [ADDR_W-1:0] wr_base_d;

  assign wr_base_d = wb_q ? BANK1_BASE : '0;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wb_q    <= 1'b1;
      db_q    <= 1'b0;
      pend_q  <= 1'b0;
      wcnt_q  <= '0;
      ccnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      // NOTE: pulse outputs default low here and are re-asserted below; with
      // non-blocking assignments the last write in the block wins.
      we_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cam_frame_start) begin
            state_q <= S_CAPTURE;
            wcnt_q  <= '0;
            if (clear_req) pend_q <= 1'b1;
          end else if (clear_req || pend_q) begin
            state_q <= S_CLEAR;
            ccnt_q  <= '0;
          end
        end
        S_CAPTURE: begin
          if (cam_valid) begin
            if (wcnt_q != FULL_CNT) begin
              we_q   <= 1'b1;
              addr_q <= wr_base_d + ADDR_W'(wcnt_q);
              data_q <= cam_data;
              wcnt_q <= wcnt_q + CNT_W'(1);
            end else begin
              ovf_q <= 1'b1;
            end
          end
          if (clear_req) pend_q <= 1'b1;
          if (cam_frame_end) state_q <= S_WAIT_SWAP;
        end
        S_WAIT_SWAP: begin
          if (clear_req) pend_q <= 1'b1;
          if (cam_frame_start && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
          if (disp_vsync) begin
            // The bank just written becomes the front bank.
            wb_q    <= db_q;
            db_q    <= wb_q;
            base_q  <= wr_base_d;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_CLEAR: begin
          if (cam_frame_start) begin
            state_q <= S_CAPTURE;
            wcnt_q  <= '0;
            pend_q  <= 1'b1;
          end else begin
            we_q   <= 1'b1;
            busy_q <= 1'b1;
            addr_q <= wr_base_d + ADDR_W'(ccnt_q);
            data_q <= FILL_VALUE;
            if (ccnt_q == LAST_CNT) begin
              state_q <= S_IDLE;
              pend_q  <= 1'b0;
            end else begin
              ccnt_q <= ccnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign disp_base  = base_q;
  assign frame_done = done_q;
  assign clear_busy = busy_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fb_bank_scheduler.sv
// Scoreboard bench for fb_bank_scheduler: a behavioural model queues the
// expected registered outputs per cycle; a negedge monitor pops and compares.
module tb_fb_bank_scheduler;

  localparam int          FW   = 8;
  localparam int          AW   = 5;
  localparam logic [31:0] FILL = 32'hDEAD_BEEF;

  logic          clk;
  logic          reset;
  logic          cam_frame_start;
  logic          cam_frame_end;
  logic          cam_valid;
  logic [31:0]   cam_data;
  logic          disp_vsync;
  logic          clear_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data;
  logic [AW-1:0] disp_base;
  logic          frame_done;
  logic          clear_busy;
  logic          overflow;
  logic [15:0]   drop_count;

  fb_bank_scheduler #(
    .FRAME_WORDS(FW),
    .ADDR_W     (AW),
    .FILL_VALUE (FILL)
  ) dut (
    .sys_clk        (clk),
    .reset          (reset),
    .cam_frame_start(cam_frame_start),
    .cam_frame_end  (cam_frame_end),
    .cam_valid      (cam_valid),
    .cam_data       (cam_data),
    .disp_vsync     (disp_vsync),
    .clear_req      (clear_req),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_data       (ram_data),
    .disp_base      (disp_base),
    .frame_done     (frame_done),
    .clear_busy     (clear_busy),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [AW-1:0] base;
    logic          done;
    logic          busy;
    logic          ovf;
    logic [15:0]   drop;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Behavioural model of the scheduler, written from the block description.
  localparam int M_IDLE = 0, M_CAP = 1, M_WAIT = 2, M_CLR = 3;
  int   m_st   = M_IDLE;
  bit   m_wb   = 1'b1;
  bit   m_db   = 1'b0;
  bit   m_pend = 1'b0;
  int   m_w    = 0;
  int   m_c    = 0;
  exp_t m_out  = '0;

  function automatic logic [AW-1:0] base_of(input bit b);
    return b ? AW'(FW) : AW'(0);
  endfunction

  task automatic model_step(input bit rst, input bit fs, input bit fe, input bit v,
                            input logic [31:0] d, input bit vs, input bit cr);
    exp_t e;
    bit   t;
    e      = m_out;
    e.we   = 1'b0;
    e.done = 1'b0;
    e.busy = 1'b0;
    if (rst) begin
      e = '0;
      m_st = M_IDLE; m_wb = 1'b1; m_db = 1'b0; m_pend = 1'b0; m_w = 0; m_c = 0;
    end else begin
      case (m_st)
        M_IDLE: begin
          if (fs) begin
            m_st = M_CAP; m_w = 0;
            if (cr) m_pend = 1'b1;
          end else if (cr || m_pend) begin
            m_st = M_CLR; m_c = 0;
          end
        end
        M_CAP: begin
          if (v) begin
            if (m_w < FW) begin
              e.we = 1'b1; e.addr = base_of(m_wb) + AW'(m_w); e.data = d; m_w++;
            end else begin
              e.ovf = 1'b1;
            end
          end
          if (cr) m_pend = 1'b1;
          if (fe) m_st = M_WAIT;
        end
        M_WAIT: begin
          if (cr) m_pend = 1'b1;
          if (fs && e.drop != 16'hFFFF) e.drop = e.drop + 16'd1;
          if (vs) begin
            t = m_wb; m_wb = m_db; m_db = t;
            e.base = base_of(m_db); e.done = 1'b1; m_st = M_IDLE;
          end
        end
        default: begin
          if (fs) begin
            m_st = M_CAP; m_w = 0; m_pend = 1'b1;
          end else begin
            e.we = 1'b1; e.busy = 1'b1; e.addr = base_of(m_wb) + AW'(m_c); e.data = FILL;
            m_c++;
            if (m_c == FW) begin
              m_st = M_IDLE; m_pend = 1'b0;
            end
          end
        end
      endcase
    end
    m_out = e;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit fs, input bit fe, input bit v,
                       input logic [31:0] d, input bit vs, input bit cr);
    reset = rst; cam_frame_start = fs; cam_frame_end = fe; cam_valid = v;
    cam_data = d; disp_vsync = vs; clear_req = cr;
    model_step(rst, fs, fe, v, d, vs, cr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic word(input logic [31:0] d);
    drive(0, 0, 0, 1, d, 0, 0);
  endtask

  task automatic count_busy(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      idle(1);
      if (clear_busy) cnt++;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("ram_we", 32'(ram_we), 32'(mon_e.we));
      if (mon_e.we) begin
        check("ram_addr", 32'(ram_addr), 32'(mon_e.addr));
        check("ram_data", ram_data, mon_e.data);
        check("addr_range", 32'(ram_addr < AW'(2 * FW)), 32'd1);
      end
      check("disp_base", 32'(disp_base), 32'(mon_e.base));
      check("frame_done", 32'(frame_done), 32'(mon_e.done));
      check("clear_busy", 32'(clear_busy), 32'(mon_e.busy));
      check("overflow", 32'(overflow), 32'(mon_e.ovf));
      check("drop_count", 32'(drop_count), 32'(mon_e.drop));
    end
  end

  initial begin
    int busy_cnt;
    #2;
    drive(1, 0, 0, 0, 32'h0, 0, 0);
    drive(1, 0, 0, 0, 32'h0, 0, 0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_base", 32'(disp_base), 32'd0);
    idle(2);

    // Short frame into bank 1, then swap on vsync.
    drive(0, 1, 0, 0, 32'h0, 0, 0);
    word(32'hA); word(32'hB); word(32'hC); word(32'hD);
    drive(0, 0, 1, 0, 32'h0, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 32'h0, 1, 0);
    check("t1_disp_base", 32'(disp_base), 32'd8);
    check("t1_frame_done", 32'(frame_done), 32'd1);
    idle(2);

    // Ten-word frame into bank 0: last two words discarded, end on last word.
    drive(0, 1, 0, 0, 32'h0, 0, 0);
    for (int i = 1; i <= 8; i++) word(32'h100 + i);
    check("t2_ovf_before", 32'(overflow), 32'd0);
    word(32'h109);
    check("t2_ovf_after", 32'(overflow), 32'd1);
    drive(0, 0, 1, 1, 32'h10A, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 32'h0, 1, 0);
    check("t2_disp_base", 32'(disp_base), 32'd0);
    idle(2);

    // Full clear of back bank 1.
    drive(0, 0, 0, 0, 32'h0, 0, 1);
    count_busy(12, busy_cnt);
    check("t3_busy_cycles", 32'(busy_cnt), 32'd8);

    // Clear aborted by a frame start at its third write, resumes after swap.
    drive(0, 0, 0, 0, 32'h0, 0, 1);
    idle(2);
    drive(0, 1, 0, 0, 32'h0, 0, 0);
    check("t4_abort_busy", 32'(clear_busy), 32'd0);
    word(32'h401);
    check("t4_cap_addr", 32'(ram_addr), 32'd8);
    word(32'h402); word(32'h403);
    drive(0, 0, 1, 0, 32'h0, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 32'h0, 1, 0);
    count_busy(12, busy_cnt);
    check("t4_busy_cycles", 32'(busy_cnt), 32'd8);

    // Two frames dropped while waiting for vsync.
    drive(0, 1, 0, 0, 32'h0, 0, 0);
    word(32'h501); word(32'h502);
    drive(0, 0, 1, 0, 32'h0, 0, 0);
    idle(1);
    drive(0, 1, 0, 0, 32'h0, 0, 0);
    word(32'h5A1); word(32'h5A2);
    drive(0, 1, 0, 0, 32'h0, 0, 0);
    word(32'h5B1);
    idle(1);
    check("t5_drop_two", 32'(drop_count), 32'd2);
    drive(0, 0, 0, 0, 32'h0, 1, 0);
    check("t5_frame_done", 32'(frame_done), 32'd1);
    check("t5_disp_base", 32'(disp_base), 32'd0);
    word(32'h5B2); word(32'h5B3);
    drive(0, 0, 1, 0, 32'h0, 0, 0);
    idle(2);

    // Frame start coincident with vsync: swap happens, frame still dropped.
    drive(0, 1, 0, 0, 32'h0, 0, 0);
    word(32'h551);
    drive(0, 0, 1, 0, 32'h0, 0, 0);
    idle(1);
    drive(0, 1, 0, 0, 32'h0, 1, 0);
    check("t5_coinc_drop", 32'(drop_count), 32'd3);
    check("t5_coinc_base", 32'(disp_base), 32'd8);
    word(32'h561);
    idle(2);

    // Reset in the middle of a capture.
    drive(0, 1, 0, 0, 32'h0, 0, 0);
    word(32'h601); word(32'h602); word(32'h603);
    drive(1, 0, 0, 0, 32'h0, 0, 0);
    check("t6_we", 32'(ram_we), 32'd0);
    check("t6_base", 32'(disp_base), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_drop", 32'(drop_count), 32'd0);
    idle(1);
    drive(0, 1, 0, 0, 32'h0, 0, 0);
    word(32'h611);
    check("t6_wb_addr", 32'(ram_addr), 32'd8);
    drive(0, 0, 1, 0, 32'h0, 0, 0);
    idle(2);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
